// File: rtl/prime_generator.sv
// Streams the primes in 2..limit in ascending order on a valid/ready port.
// Each candidate is tested by trial division, using one repeated-subtraction step per cycle.
module prime_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             prime_ready,
    output logic [WIDTH-1:0] prime,
    output logic             prime_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEXT  = 3'd1,
        S_MOD   = 3'd2,
        S_CHECK = 3'd3,
        S_EMIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    // Stream handshake: a prime transfers on a cycle where prime_valid and prime_ready are both 1.
    // Once prime_valid rises, prime and prime_valid stay unchanged until that transfer.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] prime_q, prime_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] count_q, count_d;

    logic [2*WIDTH-1:0] d_wide;
    logic [2*WIDTH-1:0] cand_wide;
    logic [2*WIDTH-1:0] d_sq;

    assign d_wide    = {{WIDTH{1'b0}}, d_q};
    assign cand_wide = {{WIDTH{1'b0}}, cand_q};
    assign d_sq      = d_wide * d_wide;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lim_q   <= '0;
            cand_q  <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            prime_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            cand_q  <= cand_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            prime_q <= prime_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        cand_d  = cand_q;
        d_d     = d_q;
        rem_d   = rem_q;
        prime_d = prime_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lim_d   = limit;
                    done_d  = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    if (limit < WIDTH'(2)) begin
                        state_d = S_FIN;
                    end else begin
                        cand_d  = WIDTH'(2);
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                d_d     = WIDTH'(2);
                rem_d   = cand_q;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (d_sq > cand_wide) begin
                    prime_d = cand_q;
                    valid_d = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    rem_d   = cand_q;
                    state_d = S_MOD;
                end
            end
            S_MOD: begin
                if (rem_q >= d_q) begin
                    rem_d = rem_q - d_q;
                end else if (rem_q == '0) begin
                    // Composite. The limit is checked before the increment, so cand never wraps.
                    if (cand_q == lim_q) begin
                        state_d = S_FIN;
                    end else begin
                        cand_d  = cand_q + WIDTH'(1);
                        state_d = S_NEXT;
                    end
                end else begin
                    d_d     = d_q + WIDTH'(1);
                    state_d = S_CHECK;
                end
            end
            S_EMIT: begin
                if (valid_q && prime_ready) begin
                    count_d = count_q + WIDTH'(1);
                    valid_d = 1'b0;
                    if (cand_q == lim_q) begin
                        state_d = S_FIN;
                    end else begin
                        cand_d  = cand_q + WIDTH'(1);
                        state_d = S_NEXT;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prime       = prime_q;
        prime_valid = valid_q;
        busy        = busy_q;
        done        = done_q;
        count       = count_q;
        dbg_state_o = state_q;
    end

endmodule
